// File: rtl/stat_frame_loader_if.sv
// Bus bundle between the sample source, stat_frame_loader, stat_calculator and the result consumer.
// master = the loader itself, slave = its environment.
interface stat_frame_loader_if;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        in_ready;
  logic [15:0] nums_out;
  logic [3:0]  op_out;
  logic [7:0]  calc_result;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [3:0]  res_op;
  logic        res_ready;
  logic        frame_done;

  modport master (
    input  in_valid, in_data, calc_result, res_ready,
    output in_ready, nums_out, op_out, res_valid, res_data, res_op, frame_done
  );

  modport slave (
    output in_valid, in_data, calc_result, res_ready,
    input  in_ready, nums_out, op_out, res_valid, res_data, res_op, frame_done
  );
endinterface

// File: rtl/stat_frame_loader.sv
// Streaming front-end for stat_calculator: loads a 4-sample frame, steps four ops, streams results.
// Define STAT_LOADER_OVERLAP_EN to collect the next frame in a shadow buffer during evaluation.
module stat_frame_loader #(
  parameter logic [3:0]  OP_IDLE       = 4'b0000,
  parameter logic [3:0]  OP_SEQ0       = 4'b1000,
  parameter logic [3:0]  OP_SEQ1       = 4'b1100,
  parameter logic [3:0]  OP_SEQ2       = 4'b1010,
  parameter logic [3:0]  OP_SEQ3       = 4'b1111,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst,
  stat_frame_loader_if.master bus
);

  typedef enum logic [1:0] {FILL, EVAL, OUT} state_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] nums_q, nums_d;
  logic        res_valid_q, res_valid_d;
  logic [7:0]  res_data_q, res_data_d;
  logic [3:0]  res_op_q, res_op_d;
  logic        frame_done_q, frame_done_d;
  logic [3:0]  op_seq;
  logic        in_ready;
  logic        accept;
  logic        load_frame;

`ifdef STAT_LOADER_OVERLAP_EN
  logic [15:0] sh_q, sh_d;
  logic [2:0]  sh_cnt_q, sh_cnt_d;

  always_comb in_ready = !rst && (sh_cnt_q != 3'd4);
`else
  logic [1:0]  cnt_q, cnt_d;

  always_comb in_ready = !rst && (state_q == FILL);
`endif

  always_comb begin
    case (k_q)
      2'd0:    op_seq = OP_SEQ0;
      2'd1:    op_seq = OP_SEQ1;
      2'd2:    op_seq = OP_SEQ2;
      default: op_seq = OP_SEQ3;
    endcase
  end

  always_comb begin
    accept       = bus.in_valid && in_ready;
    state_d      = state_q;
    k_d          = k_q;
    settle_d     = settle_q;
    nums_d       = nums_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_op_d     = res_op_q;
    frame_done_d = 1'b0;

`ifdef STAT_LOADER_OVERLAP_EN
    // A shadow that becomes full on this edge loads immediately, so latency matches the direct-fill build.
    sh_d     = sh_q;
    sh_cnt_d = sh_cnt_q;
    if (accept) begin
      sh_d[{~sh_cnt_q[1:0], 2'b00} +: 4] = bus.in_data;
      sh_cnt_d = sh_cnt_q + 3'd1;
    end
    load_frame = (state_q == FILL) && (sh_cnt_d == 3'd4);
    if (load_frame) begin
      nums_d   = sh_d;
      sh_cnt_d = '0;
    end
`else
    cnt_d      = cnt_q;
    load_frame = 1'b0;
    if (accept) begin
      nums_d[{~cnt_q, 2'b00} +: 4] = bus.in_data;
      cnt_d      = cnt_q + 2'd1;
      load_frame = (cnt_q == 2'd3);
    end
`endif

    case (state_q)
      FILL: begin
        if (load_frame) begin
          state_d  = EVAL;
          k_d      = '0;
          settle_d = SETTLE_LOAD;
        end
      end
      EVAL: begin
        if (settle_q == '0) begin
          res_data_d  = bus.calc_result;
          res_op_d    = op_seq;
          res_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      OUT: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          if (k_q == 2'd3) begin
            frame_done_d = 1'b1;
            k_d          = '0;
            state_d      = FILL;
          end else begin
            k_d      = k_q + 2'd1;
            settle_d = SETTLE_LOAD;
            state_d  = EVAL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      k_q          <= '0;
      settle_q     <= '0;
      nums_q       <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_op_q     <= '0;
      frame_done_q <= 1'b0;
`ifdef STAT_LOADER_OVERLAP_EN
      sh_q         <= '0;
      sh_cnt_q     <= '0;
`else
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      settle_q     <= settle_d;
      nums_q       <= nums_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_op_q     <= res_op_d;
      frame_done_q <= frame_done_d;
`ifdef STAT_LOADER_OVERLAP_EN
      sh_q         <= sh_d;
      sh_cnt_q     <= sh_cnt_d;
`else
      cnt_q        <= cnt_d;
`endif
    end
  end

  always_comb begin
    bus.in_ready   = in_ready;
    bus.nums_out   = nums_q;
    bus.op_out     = (state_q == FILL) ? OP_IDLE : op_seq;
    bus.res_valid  = res_valid_q;
    bus.res_data   = res_data_q;
    bus.res_op     = res_op_q;
    bus.frame_done = frame_done_q;
  end

endmodule
